// File: rtl/hcsr04_pkg.sv
// Shared types and default timing for the HC-SR04 ranger interface.
package hcsr04_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_ECHO = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  // Defaults assume a 50 MHz system clock.
  localparam int unsigned DEF_CLK_HZ        = 50_000_000;
  localparam int unsigned DEF_TRIG_CYCLES   = 500;        // 10 us trigger pulse
  localparam int unsigned DEF_CYCLES_PER_MM = 294;        // round-trip sound time per mm
  localparam int unsigned DEF_ECHO_WAIT_MAX = 1_000_000;  // 20 ms for echo to start
  localparam int unsigned DEF_ECHO_HIGH_MAX = 1_900_000;  // 38 ms max echo width

  localparam int CNT_W = 21;  // cycle / timeout counter
  localparam int PRE_W = 9;   // cycles-per-mm prescaler
  localparam int MM_W  = 16;  // millimetre counter

  localparam logic [MM_W-1:0] DIST_TIMEOUT = 16'hFFFF;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing the asynchronous echo pin into the clock domain.
module sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the raw input through two flops; both clear on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/hcsr04_sensor.sv
// HC-SR04 controller: trigger pulse, echo timing, distance in mm with a done level.
//
// Handshake: i_start is a request sampled only in IDLE or DONE; o_done is a level that
// stays high with o_distance stable until the next accepted start. There is no ready
// signal -- a start seen in any other state is simply dropped.
module hcsr04_sensor
  import hcsr04_pkg::*;
#(
  parameter int unsigned CLK_HZ        = DEF_CLK_HZ,
  parameter int unsigned TRIG_CYCLES   = DEF_TRIG_CYCLES,
  parameter int unsigned CYCLES_PER_MM = DEF_CYCLES_PER_MM,
  parameter int unsigned ECHO_WAIT_MAX = DEF_ECHO_WAIT_MAX,
  parameter int unsigned ECHO_HIGH_MAX = DEF_ECHO_HIGH_MAX
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  output logic            o_trigger,
  input  logic            i_echo,
  output logic            o_done,
  output logic [MM_W-1:0] o_distance,
  output state_t          o_dbg_state
);

  // The clock rate only documents where the default cycle counts come from.
  if (CLK_HZ == 0) begin : g_bad_clk
    $error("hcsr04_sensor: CLK_HZ must be nonzero");
  end

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ECHO_WAIT_MAX - 1);
  localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(ECHO_HIGH_MAX - 1);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CYCLES_PER_MM - 1);
  // The cycle where echo is first seen is itself an echo-high cycle, so MEASURE is
  // entered with that first prescaler step already applied.
  localparam logic [PRE_W-1:0] PRE_FIRST = (CYCLES_PER_MM == 1) ? '0 : PRE_W'(1);
  localparam logic [MM_W-1:0]  MM_FIRST  = (CYCLES_PER_MM == 1) ? MM_W'(1) : '0;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [PRE_W-1:0]  r_pre, w_pre_nxt, w_pre_inc;
  logic [MM_W-1:0]   r_mm, w_mm_nxt, w_mm_inc;
  logic              r_trig, w_trig_nxt;
  logic              r_done, w_done_nxt;
  logic [MM_W-1:0]   r_dist, w_dist_nxt;
  logic              w_echo_s;

  sync2 u_echo_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_echo),
    .o_q     (w_echo_s)
  );

  // One echo-high cycle: prescaler wraps at CYCLES_PER_MM and carries into the mm count.
  always_comb begin
    w_pre_inc = r_pre + PRE_W'(1);
    w_mm_inc  = r_mm;
    if (r_pre == PRE_LAST) begin
      w_pre_inc = '0;
      w_mm_inc  = r_mm + MM_W'(1);
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Counters and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_pre  <= '0;
      r_mm   <= '0;
      r_trig <= 1'b0;
      r_done <= 1'b0;
      r_dist <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_pre  <= w_pre_nxt;
      r_mm   <= w_mm_nxt;
      r_trig <= w_trig_nxt;
      r_done <= w_done_nxt;
      r_dist <= w_dist_nxt;
    end
  end

  // Next-state and next-register values for the measurement sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pre_nxt   = r_pre;
    w_mm_nxt    = r_mm;
    w_trig_nxt  = r_trig;
    w_done_nxt  = r_done;
    w_dist_nxt  = r_dist;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_state_nxt = ST_TRIG;
          w_cnt_nxt   = '0;
          w_trig_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
        end
      end
      ST_TRIG: begin
        if (r_cnt == TRIG_LAST) begin
          w_state_nxt = ST_WAIT_ECHO;
          w_cnt_nxt   = '0;
          w_trig_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_WAIT_ECHO: begin
        if (w_echo_s) begin
          w_state_nxt = ST_MEASURE;
          w_cnt_nxt   = CNT_W'(1);
          w_pre_nxt   = PRE_FIRST;
          w_mm_nxt    = MM_FIRST;
        end else if (r_cnt == WAIT_LAST) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
          w_dist_nxt  = DIST_TIMEOUT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_MEASURE: begin
        if (!w_echo_s) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
          w_dist_nxt  = r_mm;
        end else if (r_cnt == HIGH_LAST) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
          w_dist_nxt  = DIST_TIMEOUT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          w_pre_nxt = w_pre_inc;
          w_mm_nxt  = w_mm_inc;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_trigger   = r_trig;
  assign o_done      = r_done;
  assign o_distance  = r_dist;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hcsr04_sensor.sv
// Directed + randomized bench for hcsr04_sensor with scaled-down timing.
module tb_hcsr04_sensor;
  import hcsr04_pkg::*;

  localparam int TRIG_C   = 50;
  localparam int CPM      = 13;
  localparam int WAIT_MAX = 2000;
  localparam int HIGH_MAX = 20000;
  localparam int ECHO_DLY = 5;   // 100 ns at 50 MHz

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        echo = 1'b0;
  logic        trigger;
  logic        done;
  logic [15:0] distance;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #10 clk = ~clk;

  hcsr04_sensor #(
    .CLK_HZ        (50_000_000),
    .TRIG_CYCLES   (TRIG_C),
    .CYCLES_PER_MM (CPM),
    .ECHO_WAIT_MAX (WAIT_MAX),
    .ECHO_HIGH_MAX (HIGH_MAX)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .o_trigger   (trigger),
    .i_echo      (echo),
    .o_done      (done),
    .o_distance  (distance),
    .o_dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  // Distance is whole millimetres of echo time; overly long echoes read as timeout.
  function automatic logic [15:0] model_dist(input int n_high);
    if (n_high == 0 || n_high >= HIGH_MAX) return 16'hFFFF;
    return 16'(n_high / CPM);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Pulse start, time trigger, drive an n_high-cycle echo (none if 0), time done.
  task automatic run_meas(input int n_high, input int delay, input bit poke,
                          output int trig_len, output int lat);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_cleared_on_start", done, 0);
    trig_len = 0;
    while (trigger === 1'b1 && trig_len < 10 * TRIG_C) begin
      trig_len++;
      start = (poke && trig_len == TRIG_C / 2);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (delay) @(negedge clk);
    if (n_high > 0) begin
      echo = 1'b1;
      for (int i = 0; i < n_high; i++) begin
        start = (poke && i == n_high / 2);
        @(negedge clk);
      end
      start = 1'b0;
      echo  = 1'b0;
    end
    lat = 0;
    while (done !== 1'b1 && lat < WAIT_MAX + 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic meas_check(input string tag, input int n_high, input int delay, input bit poke);
    int tl, lat;
    run_meas(n_high, delay, poke, tl, lat);
    check($sformatf("%s trig_len", tag), tl, TRIG_C);
    check($sformatf("%s latency", tag), lat, (n_high == 0) ? WAIT_MAX - delay : 3);
    check($sformatf("%s done", tag), done, 1);
    check($sformatf("%s distance", tag), distance, model_dist(n_high));
  endtask

  // Start a measurement and return once trigger has fallen (bounded).
  task automatic start_and_wait_trig;
    int k;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (trigger === 1'b1 && k < 10 * TRIG_C) begin
      k++;
      @(negedge clk);
    end
    check("trig_len_pre", k, TRIG_C);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, d, k;
    logic [15:0] held;

    // reset state
    #35;
    check("reset trigger", trigger, 0);
    check("reset done", done, 0);
    check("reset distance", distance, 0);
    check("reset state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // basic and back-to-back measurements
    meas_check("d100", 100 * CPM, ECHO_DLY, 1'b0);
    meas_check("d500", 500 * CPM, ECHO_DLY, 1'b0);
    meas_check("d1000", 1000 * CPM, ECHO_DLY, 1'b0);

    // prescaler boundaries
    meas_check("b_cpm_m1", CPM - 1, ECHO_DLY, 1'b0);
    meas_check("b_cpm", CPM, ECHO_DLY, 1'b0);
    meas_check("b_2cpm_m1", 2 * CPM - 1, ECHO_DLY, 1'b0);
    meas_check("b_2cpm", 2 * CPM, ECHO_DLY, 1'b0);

    // randomized echo widths and start delays
    for (int i = 0; i < 8; i++) begin
      n = $urandom_range(1, 700);
      d = $urandom_range(0, 10);
      meas_check($sformatf("rand%0d_n%0d", i, n), n, d, 1'b0);
    end

    // no echo -> wait timeout
    meas_check("no_echo", 0, 0, 1'b0);

    // echo stuck high -> high-time timeout
    start_and_wait_trig();
    repeat (ECHO_DLY) @(negedge clk);
    echo = 1'b1;
    k = 0;
    while (done !== 1'b1 && k < HIGH_MAX + 100) begin
      @(negedge clk);
      k++;
    end
    check("stuck done", done, 1);
    check("stuck distance", distance, 16'hFFFF);
    echo = 1'b0;
    repeat (5) @(negedge clk);
    meas_check("after_stuck", 37 * CPM + 4, ECHO_DLY, 1'b0);

    // starts during TRIG and MEASURE are ignored; done holds afterwards
    meas_check("poke", 30 * CPM, ECHO_DLY, 1'b1);
    held = model_dist(30 * CPM);
    repeat (50) @(negedge clk);
    check("hold done", done, 1);
    check("hold distance", distance, held);
    check("hold state", dbg_state, ST_DONE);

    // reset during MEASURE
    start_and_wait_trig();
    repeat (ECHO_DLY) @(negedge clk);
    echo = 1'b1;
    repeat (40) @(negedge clk);
    check("pre_rst state", dbg_state, ST_MEASURE);
    rst_n = 1'b0;
    #1;
    check("rst_meas trigger", trigger, 0);
    check("rst_meas done", done, 0);
    check("rst_meas distance", distance, 0);
    echo = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    meas_check("after_rst", 50 * CPM, ECHO_DLY, 1'b0);

    // reset during TRIG drops trigger at once
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst trigger", trigger, 1);
    rst_n = 1'b0;
    #1;
    check("rst_trig trigger", trigger, 0);
    check("rst_trig distance", distance, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    meas_check("final", 7 * CPM + 12, ECHO_DLY, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
